// File: rtl/dma_wr_64to32.sv
// dma_wr_64to32: drains 64-bit FIFO words into 32-bit memory writes (define DMA_WR_BSWAP_EN to byte-reverse each half)
module dma_wr_64to32 #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [31:0]      desc_addr,
  input  logic [LEN_W-1:0] desc_len,
  input  logic [63:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             mem_wren,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_gnt,
  output logic             done,
  output logic [LEN_W-1:0] done_len
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam logic [LEN_W-1:0] ONE = 1;
  state_t state, state_nx;
  logic [31:0] cur_addr, half;
  logic [LEN_W-1:0] remain, moved;
  logic acc;
  // next state plus the combinational write, pop and descriptor handshake outputs
  always_comb begin
    desc_ready = state == IDLE;
    mem_wren = state == LO ? !fifo_empty : state == HI;
    acc = mem_wren && mem_gnt;
    fifo_rd_en = state == HI && mem_gnt;
    mem_addr = cur_addr;
    half = state == HI ? fifo_dout[63:32] : fifo_dout[31:0];
    state_nx = state == IDLE ? (desc_valid ? (desc_len == '0 ? DONE : LO) : IDLE)
             : state == LO   ? (acc ? HI : LO)
             : state == HI   ? (acc ? (remain == ONE ? DONE : LO) : HI)
             : IDLE;
  end
`ifdef DMA_WR_BSWAP_EN
  assign mem_wdata = {half[7:0], half[15:8], half[23:16], half[31:24]};
`else
  assign mem_wdata = half;
`endif
  // state register
  always_ff @(posedge clk or posedge srst)
    if (srst) state <= IDLE;
    else state <= state_nx;
  // descriptor bookkeeping; the pop strobe doubles as the per-word completion event
  always_ff @(posedge clk or posedge srst)
    if (srst) begin
      cur_addr <= '0;
      remain <= '0;
      moved <= '0;
      done <= 1'b0;
      done_len <= '0;
    end else begin
      done <= state_nx == DONE;
      if (state_nx == DONE) done_len <= state == IDLE ? '0 : moved + ONE;
      if (state == IDLE && desc_valid) begin
        cur_addr <= desc_addr & ~32'h3;
        remain <= desc_len;
        moved <= '0;
      end
      if (acc) cur_addr <= cur_addr + 32'd4;
      if (fifo_rd_en) begin
        remain <= remain - ONE;
        moved <= moved + ONE;
      end
    end
endmodule
